// File: rtl/cacheline_mem_arbiter_pkg.sv
// rtl/cacheline_mem_arbiter_pkg.sv - shared types and constants for the cacheline memory arbiter
package cacheline_mem_arbiter_pkg;

  localparam int LINE_W_DEF = 256;
  localparam int LINE_OFS   = 5;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY_I = 2'd1;
  localparam logic [1:0] ST_BUSY_D = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_e;

endpackage

// File: rtl/cacheline_mem_arbiter_sat_counter.sv
// rtl/cacheline_mem_arbiter_sat_counter.sv - increment-by-one counter that sticks at all-ones
module cacheline_mem_arbiter_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/cacheline_mem_arbiter.sv
// rtl/cacheline_mem_arbiter.sv - shares one cacheline memory port between I-cache and D-cache misses
module cacheline_mem_arbiter
  import cacheline_mem_arbiter_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEF,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [CNT_W-1:0]  cnt_i_grants,
  output logic [CNT_W-1:0]  cnt_d_grants,
  output logic [CNT_W-1:0]  cnt_conflicts
);

  logic [1:0]        r_state;
  req_e              r_owner;
  req_e              r_last_grant;
  logic              r_pmem_read;
  logic              r_pmem_write;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic [LINE_W-1:0] r_line;

  logic w_idle;
  logic w_req_i;
  logic w_req_d;
  logic w_grant_i;
  logic w_grant_d;
  logic w_conflict;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_req_i    = i_read;
  assign w_req_d    = d_read | d_write;
  // On a tie the side that did not win last time goes first.
  assign w_grant_d  = w_idle && w_req_d && (!w_req_i || (r_last_grant == REQ_I));
  assign w_grant_i  = w_idle && w_req_i && !w_grant_d;
  assign w_conflict = w_idle && w_req_i && w_req_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_owner      <= REQ_I;
      r_last_grant <= REQ_I;
      r_pmem_read  <= 1'b0;
      r_pmem_write <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_line       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_d) begin
            r_state      <= ST_BUSY_D;
            r_owner      <= REQ_D;
            r_addr       <= {d_addr[ADDR_W-1:LINE_OFS], {LINE_OFS{1'b0}}};
            r_pmem_read  <= d_read;
            r_pmem_write <= d_write;
            if (d_write) begin
              r_wdata <= d_wdata;
            end
          end else if (w_grant_i) begin
            r_state      <= ST_BUSY_I;
            r_owner      <= REQ_I;
            r_addr       <= {i_addr[ADDR_W-1:LINE_OFS], {LINE_OFS{1'b0}}};
            r_pmem_read  <= 1'b1;
            r_pmem_write <= 1'b0;
          end
        end
        ST_BUSY_I, ST_BUSY_D: begin
          if (pmem_resp) begin
            r_state      <= ST_DONE;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            r_line       <= pmem_rdata;
          end
        end
        ST_DONE: begin
          r_last_grant <= r_owner;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign pmem_read  = r_pmem_read;
  assign pmem_write = r_pmem_write;
  assign pmem_addr  = r_addr;
  assign pmem_wdata = r_wdata;
  assign i_rdata    = r_line;
  assign d_rdata    = r_line;
  assign i_resp     = (r_state == ST_DONE) && (r_owner == REQ_I);
  assign d_resp     = (r_state == ST_DONE) && (r_owner == REQ_D);

  cacheline_mem_arbiter_sat_counter #(.W(CNT_W)) u_cnt_i (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_grant_i),
    .o_count (cnt_i_grants)
  );

  cacheline_mem_arbiter_sat_counter #(.W(CNT_W)) u_cnt_d (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_grant_d),
    .o_count (cnt_d_grants)
  );

  cacheline_mem_arbiter_sat_counter #(.W(CNT_W)) u_cnt_conflict (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_conflict),
    .o_count (cnt_conflicts)
  );

endmodule
